// File: rtl/ff_pipe_sync_set.sv
// Enable-gated shift pipeline with async reset, synchronous set and a valid-occupancy counter.
// Define FF_PIPE_SET_VALID_EN to make the set also mark every stage valid (otherwise the set clears them).
module ff_pipe_sync_set #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       S,
    input  logic                       en,
    input  logic [WIDTH-1:0]           D,
    input  logic                       vld_in,
    output logic [WIDTH-1:0]           Q,
    output logic                       vld_out,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_cnt;

    // Occupancy update for one shift: a word entering and one leaving cancel out.
    function automatic logic [CW-1:0] f_cnt_next(input logic [CW-1:0] c,
                                                 input logic          add,
                                                 input logic          sub);
        logic [CW-1:0] n;
        n = c;
        if (add && !sub)
            n = c + CW'(1);
        else if (!add && sub)
            n = c - CW'(1);
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                r_data[k] <= '0;
            r_vld <= '0;
            r_cnt <= '0;
        end else if (S) begin
            for (int k = 0; k < DEPTH; k++)
                r_data[k] <= SET_VAL;
`ifdef FF_PIPE_SET_VALID_EN
            r_vld <= '1;
            r_cnt <= CW'(DEPTH);
`else
            r_vld <= '0;
            r_cnt <= '0;
`endif
        end else if (en) begin
            r_data[0] <= D;
            r_vld[0]  <= vld_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
            r_cnt <= f_cnt_next(r_cnt, vld_in, r_vld[DEPTH-1]);
        end
    end

    assign Q       = r_data[DEPTH-1];
    assign vld_out = r_vld[DEPTH-1];
    assign cnt     = r_cnt;
    assign full    = (r_cnt == CW'(DEPTH));
    assign empty   = (r_cnt == '0);

endmodule

// File: tb/tb_ff_pipe_sync_set.sv
// Self-checking bench for ff_pipe_sync_set (WIDTH=8, DEPTH=4, SET_VAL=8'hFF) using a queue-based reference pipeline.
module tb_ff_pipe_sync_set;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

`ifdef FF_PIPE_SET_VALID_EN
    localparam logic SET_V = 1'b1;
`else
    localparam logic SET_V = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             S = 1'b0;
    logic             en = 1'b0;
    logic             vld_in = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic [WIDTH-1:0] Q;
    logic             vld_out;
    logic [2:0]       cnt;
    logic             full;
    logic             empty;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } stage_t;

    // pipe[0] is the output stage, pipe[$] the input stage.
    stage_t      pipe[$];
    logic [13:0] exp_q[$];

    ff_pipe_sync_set #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SET_VAL(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .S(S), .en(en), .D(D), .vld_in(vld_in),
        .Q(Q), .vld_out(vld_out), .cnt(cnt), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] model_out();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (pipe[i].v) n++;
        return {pipe[0].d, pipe[0].v, 3'(n), (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic [13:0] act();
        return {Q, vld_out, cnt, full, empty};
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < DEPTH; i++)
            pipe.push_back(stage_t'(0));
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs.
    task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] d);
        S = s; en = e; vld_in = v; D = d;
        if (s) begin
            for (int i = 0; i < DEPTH; i++)
                pipe[i] = {8'hFF, SET_V};
        end else if (e) begin
            pipe.push_back({d, v});
            void'(pipe.pop_front());
        end
        exp_q.push_back(model_out());
    endtask

    task automatic test_reset();
        logic [13:0] e;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        e = {8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL reset_async act=%h exp=%h", act(), e);
        end
        en = 1'b1; vld_in = 1'b1; D = 8'h99;
        @(posedge clk); #1;
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL reset_held act=%h exp=%h", act(), e);
        end
        #5 rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [13:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(i + 1));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL stream[%0d] act=%h exp=%h", i, act(), e);
            end
            if (i == 3) begin
                checks++;
                if (Q !== 8'h01 || vld_out !== 1'b1 || cnt !== 3'd4 || full !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_first_out Q=%h v=%b cnt=%0d full=%b exp Q=01 v=1 cnt=4 full=1",
                             Q, vld_out, cnt, full);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [13:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'($urandom), 8'($urandom));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL hold[%0d] act=%h exp=%h", i, act(), e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(8 + i));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL resume[%0d] act=%h exp=%h", i, act(), e);
            end
            if (i == 0) begin
                checks++;
                if (Q !== 8'h05) begin
                    errors++;
                    $display("FAIL resume_next Q=%h exp=05", Q);
                end
            end
        end
    endtask

    task automatic test_set();
        logic [13:0] e;
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL set act=%h exp=%h", act(), e);
        end
        checks++;
        if (Q !== 8'hFF || vld_out !== SET_V || cnt !== (SET_V ? 3'd4 : 3'd0)) begin
            errors++;
            $display("FAIL set_values Q=%h v=%b cnt=%0d exp Q=ff v=%b cnt=%0d",
                     Q, vld_out, cnt, SET_V, SET_V ? 4 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL after_set[%0d] act=%h exp=%h", i, act(), e);
            end
        end
    endtask

    task automatic test_drain();
        logic [13:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e || cnt !== 3'(3 - i)) begin
                errors++;
                $display("FAIL drain[%0d] act=%h exp=%h cnt=%0d exp_cnt=%0d", i, act(), e, cnt, 3 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty empty=%b full=%b exp empty=1 full=0", empty, full);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'(i % 2 == 0), 8'(8'h50 + i));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL alternate[%0d] act=%h exp=%h", i, act(), e);
            end
        end
        checks++;
        if (cnt !== 3'd2) begin
            errors++;
            $display("FAIL alternate_steady cnt=%0d exp=2", cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(8'h30 + i));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL refill[%0d] act=%h exp=%h", i, act(), e);
            end
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        e = {8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL midreset act=%h exp=%h", act(), e);
        end
        en = 1'b1; vld_in = 1'b1; D = 8'h77;
        @(posedge clk); #1;
        checks++;
        if (act() !== e) begin
            errors++;
            $display("FAIL midreset_held act=%h exp=%h", act(), e);
        end
        #3 rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'hA5);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (act() !== e || cnt !== 3'd1 || Q !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_first act=%h exp=%h", act(), e);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (act() !== e) begin
                errors++;
                $display("FAIL post_reset[%0d] act=%h exp=%h", i, act(), e);
            end
        end
        checks++;
        if (Q !== 8'hA5 || vld_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_out Q=%h v=%b exp Q=a5 v=1", Q, vld_out);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_set();
        test_drain();
        test_async_reset();
        S = 1'b0; en = 1'b0; vld_in = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
